// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory bus between an instruction requester and a data
// requester. One transaction is in flight at a time:
//   IDLE   -> pick a requester, register its request onto m_*
//   BUSY_x -> hold m_* stable until m_ack_n is sampled low or the busy
//             counter runs out (timeout abort)
//   RESP   -> pulse the granted side's ack_n low for one cycle, then IDLE
//
// Handshake: a requester raises req with its inputs and holds both until
// its ack_n is seen low for one cycle; it drops (or replaces) req in the
// following cycle. The memory side sees m_req held high with stable m_*
// until it drives m_ack_n low for the cycle in which it is returning data.
// m_ack_n is only meaningful while m_req is high.
//
// Data normally wins arbitration. Every data grant taken while an
// instruction request is waiting bumps a starvation counter; once that
// counter reaches STARVE_LIMIT the instruction side wins the next contest.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   i_req, i_addr       instruction fetch request (always a word read)
//   i_rdata, i_ack_n    fetch data and active-low completion pulse
//   d_req, d_write,     data request: direction, size (00 word, 01 half,
//   d_size, d_addr,     10 byte), address and write data
//   d_wdata
//   d_rdata, d_ack_n    load data and active-low completion pulse
//   m_req .. m_wdata    registered request towards memory
//   m_rdata, m_ack_n    memory response (m_ack_n active-low)
//   bus_err             one-cycle pulse in the RESP cycle of a timeout
//   err_addr            address of the most recently aborted transaction
//   dbg_state           current FSM state (IDLE=0, BUSY_I=1, BUSY_D=2,
//                       RESP=3)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack_n,

    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack_n,

    output logic        m_req,
    output logic        m_write,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack_n,

    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [1:0]  dbg_state
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // Value of the busy counter in the last BUSY cycle before an abort.
    localparam logic [TW-1:0] BUSY_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q,    state_d;
    logic [SW-1:0] starve_q,   starve_d;
    logic [TW-1:0] busy_cnt_q, busy_cnt_d;

    logic          m_req_q,    m_req_d;
    logic          m_write_q,  m_write_d;
    logic [1:0]    m_size_q,   m_size_d;
    logic [31:0]   m_addr_q,   m_addr_d;
    logic [31:0]   m_wdata_q,  m_wdata_d;

    logic [31:0]   i_rdata_q,  i_rdata_d;
    logic [31:0]   d_rdata_q,  d_rdata_d;
    logic          i_ack_n_q,  i_ack_n_d;
    logic          d_ack_n_q,  d_ack_n_d;
    logic          bus_err_q,  bus_err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    // Instruction side wins only when data is absent or when it has been
    // passed over STARVE_LIMIT times in a row.
    logic grant_i;
    assign grant_i = i_req && (!d_req || (starve_q == STARVE_MAX));

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        busy_cnt_d = busy_cnt_q;
        m_req_d    = m_req_q;
        m_write_d  = m_write_q;
        m_size_d   = m_size_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_addr_d = err_addr_q;
        // Ack and error pulses last exactly one cycle: they are only ever
        // set on the edge into RESP and fall back here on the next edge.
        i_ack_n_d  = 1'b1;
        d_ack_n_d  = 1'b1;
        bus_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d    = BUSY_I;
                    m_req_d    = 1'b1;
                    m_write_d  = 1'b0;
                    m_size_d   = 2'b00;
                    m_addr_d   = i_addr;
                    m_wdata_d  = 32'd0;
                    starve_d   = '0;
                    busy_cnt_d = '0;
                end else if (d_req) begin
                    state_d    = BUSY_D;
                    m_req_d    = 1'b1;
                    m_write_d  = d_write;
                    m_size_d   = d_size;
                    m_addr_d   = d_addr;
                    m_wdata_d  = d_wdata;
                    busy_cnt_d = '0;
                    // Only a data grant that actually overtook a waiting
                    // fetch counts towards starvation.
                    if (!i_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end

            BUSY_I, BUSY_D: begin
                if (!m_ack_n) begin
                    // A real acknowledge wins even on the timeout edge.
                    state_d = RESP;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ack_n_d = 1'b0;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_n_d = 1'b0;
                        if (!m_write_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end else if (busy_cnt_q == BUSY_LAST) begin
                    state_d    = RESP;
                    m_req_d    = 1'b0;
                    bus_err_d  = 1'b1;
                    err_addr_d = m_addr_q;
                    if (state_q == BUSY_I) begin
                        i_ack_n_d = 1'b0;
                        i_rdata_d = 32'd0;
                    end else begin
                        d_ack_n_d = 1'b0;
                        d_rdata_d = 32'd0;
                    end
                end else begin
                    busy_cnt_d = busy_cnt_q + TW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            busy_cnt_q <= '0;
            m_req_q    <= 1'b0;
            m_write_q  <= 1'b0;
            m_size_q   <= 2'b00;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
            i_ack_n_q  <= 1'b1;
            d_ack_n_q  <= 1'b1;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            busy_cnt_q <= busy_cnt_d;
            m_req_q    <= m_req_d;
            m_write_q  <= m_write_d;
            m_size_q   <= m_size_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_ack_n_q  <= i_ack_n_d;
            d_ack_n_q  <= d_ack_n_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_write   = m_write_q;
    assign m_size    = m_size_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack_n   = i_ack_n_q;
    assign d_ack_n   = d_ack_n_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack_n;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack_n;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack_n;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [1:0]  dbg_state;

  mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .bus_err(bus_err), .err_addr(err_addr), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
  endtask

  // ---------------- memory device model ----------------
  // Address map of the fake memory:
  //   0xDxxxxxxx never acknowledges (forces a timeout)
  //   0xBxxxxxxx acknowledges in BUSY cycle 15 (same edge as the timeout)
  //   0xCxxxxxxx acknowledges in BUSY cycle 14
  //   0x00000100 acknowledges in BUSY cycle 1 with 0x00000513
  //   others     acknowledge in BUSY cycle addr[5:4]
  function automatic int lat_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 1;
    if (a[31:28] == 4'hB) return 15;
    if (a[31:28] == 4'hC) return 14;
    return int'(a[5:4]);
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0513;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  bit resp_busy = 0;
  int resp_cnt  = 0;

  initial begin
    m_ack_n = 1'b1;
    m_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (m_req) begin
        if (!resp_busy) begin
          resp_busy = 1;
          resp_cnt  = 0;
        end else begin
          resp_cnt++;
        end
        if (m_addr[31:28] != 4'hD && resp_cnt == lat_fn(m_addr)) begin
          m_ack_n = 1'b0;
          m_rdata = mem_fn(m_addr);
        end else begin
          m_ack_n = 1'b1;
          m_rdata = $urandom;
        end
      end else begin
        // Noise on the response lines while nothing is outstanding.
        resp_busy = 0;
        m_ack_n   = 1'($urandom_range(0, 1));
        m_rdata   = $urandom;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  typedef struct packed {
    logic        side;      // 0 instruction, 1 data
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timeout;
    logic [4:0]  busy_len;
  } exp_t;

  exp_t        exp_q[$];
  item_t       i_items[$];
  item_t       d_items[$];
  int          starve_m  = 0;
  logic [31:0] last_d_m  = 32'd0;

  task automatic push_exp(input bit side, input item_t it);
    exp_t e;
    int   lat;
    e.side    = side;
    e.write   = side ? it.write : 1'b0;
    e.size    = side ? it.size : 2'b00;
    e.addr    = it.addr;
    e.wdata   = side ? it.wdata : 32'd0;
    e.timeout = (it.addr[31:28] == 4'hD);
    lat       = lat_fn(it.addr);
    e.busy_len = e.timeout ? 5'(TIMEOUT) : 5'(lat + 1);
    if (e.timeout) e.rdata = 32'd0;
    else if (side && it.write) e.rdata = last_d_m;
    else e.rdata = mem_fn(it.addr);
    if (side) last_d_m = e.rdata;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  bit   mon_en     = 0;
  bit   have_cur   = 0;
  bit   prev_m_req = 0;
  int   busy_cnt   = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (m_req && !prev_m_req) begin
        if (exp_q.size() == 0) begin
          check_eq("grant_unexpected", m_addr, 32'hFFFF_FFFF);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1;
          busy_cnt = 1;
          check_eq("grant_addr", m_addr, cur.addr);
          check_eq("grant_ctrl", {29'd0, m_write, m_size}, {29'd0, cur.write, cur.size});
          check_eq("grant_wdata", m_wdata, cur.wdata);
        end
      end else if (m_req) begin
        busy_cnt++;
        if (have_cur && (m_addr !== cur.addr || m_wdata !== cur.wdata ||
                         m_write !== cur.write || m_size !== cur.size))
          check_eq("busy_stable_addr", m_addr, cur.addr);
      end
      if (!i_ack_n || !d_ack_n) begin
        if (!have_cur) begin
          check_eq("ack_unexpected", {30'd0, i_ack_n, d_ack_n}, 32'd3);
        end else begin
          check_eq("ack_side", {30'd0, i_ack_n, d_ack_n}, cur.side ? 32'd2 : 32'd1);
          check_eq("rdata", cur.side ? d_rdata : i_rdata, cur.rdata);
          check_eq("bus_err", {31'd0, bus_err}, {31'd0, cur.timeout});
          if (cur.timeout) check_eq("err_addr", err_addr, cur.addr);
          check_eq("busy_len", busy_cnt, {27'd0, cur.busy_len});
          check_eq("ack_after_busy", {31'd0, prev_m_req}, 32'd1);
          have_cur = 0;
        end
      end
      if (bus_err && i_ack_n && d_ack_n)
        check_eq("bus_err_stray", {31'd0, bus_err}, 32'd0);
    end
    prev_m_req = m_req;
  end

  // ---------------- drivers ----------------
  task automatic wait_ack(input bit side, output bit ok);
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((side ? d_ack_n : i_ack_n) == 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("ack_wait", {31'd0, side ? d_ack_n : i_ack_n}, 32'd0);
  endtask

  task automatic drive_i();
    bit ok;
    for (int k = 0; k < i_items.size(); k++) begin
      i_req  = 1'b1;
      i_addr = i_items[k].addr;
      wait_ack(1'b0, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
    end
    i_req  = 1'b0;
    i_addr = $urandom;
  endtask

  task automatic drive_d();
    bit ok;
    for (int k = 0; k < d_items.size(); k++) begin
      d_req   = 1'b1;
      d_write = d_items[k].write;
      d_size  = d_items[k].size;
      d_addr  = d_items[k].addr;
      d_wdata = d_items[k].wdata;
      wait_ack(1'b1, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
    end
    d_req   = 1'b0;
    d_addr  = $urandom;
    d_wdata = $urandom;
  endtask

  // Both requesters start together; each contest is decided from the
  // pending sets and the number of data wins since the fetch began waiting.
  task automatic run_round();
    int ii = 0;
    int di = 0;
    bit pick_i;
    while (ii < i_items.size() || di < d_items.size()) begin
      if (ii < i_items.size() && di < d_items.size()) pick_i = (starve_m == STARVE_LIMIT);
      else pick_i = (ii < i_items.size());
      if (pick_i) begin
        push_exp(1'b0, i_items[ii]);
        ii++;
        starve_m = 0;
      end else begin
        if (ii < i_items.size()) starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
        else starve_m = 0;
        push_exp(1'b1, d_items[di]);
        di++;
      end
    end
    @(posedge clk);
    #1;
    fork
      drive_i();
      drive_d();
    join
    repeat (3) @(negedge clk);
    check_eq("round_drain", exp_q.size(), 32'd0);
    i_items.delete();
    d_items.delete();
  endtask

  function automatic item_t mk_item(input logic w, input logic [1:0] s,
                                    input logic [31:0] a, input logic [31:0] wd);
    item_t it;
    it.write = w;
    it.size  = s;
    it.addr  = a;
    it.wdata = wd;
    return it;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 19);
    if (sel == 0) return {4'hD, r[27:0]};
    if (sel == 1) return {4'hB, r[27:0]};
    if (sel == 2) return {4'hC, r[27:0]};
    return {1'b0, r[30:0]};
  endfunction

  // ---------------- main sequence ----------------
  int acks_seen;
  int mreq_seen;

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = 32'd0; d_wdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_req", {31'd0, m_req}, 32'd0);
    check_eq("rst_m_ctrl", {29'd0, m_write, m_size}, 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_m_wdata", m_wdata, 32'd0);
    check_eq("rst_rdata", i_rdata | d_rdata, 32'd0);
    check_eq("rst_acks", {30'd0, i_ack_n, d_ack_n}, 32'd3);
    check_eq("rst_err", {31'd0, bus_err} | err_addr, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);

    // Fetch from 0x100 with the request already up at reset release:
    // granted on the first rising edge, data returned in cycle 3.
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    rst    = 1'b1;
    @(negedge clk);
    check_eq("fetch_c1_m_req", {31'd0, m_req}, 32'd1);
    check_eq("fetch_c1_m_addr", m_addr, 32'h0000_0100);
    check_eq("fetch_c1_m_size", {30'd0, m_size}, 32'd0);
    @(negedge clk);
    check_eq("fetch_c2_m_req", {31'd0, m_req}, 32'd1);
    check_eq("fetch_c2_i_ack_n", {31'd0, i_ack_n}, 32'd1);
    @(negedge clk);
    check_eq("fetch_c3_i_ack_n", {31'd0, i_ack_n}, 32'd0);
    check_eq("fetch_c3_i_rdata", i_rdata, 32'h0000_0513);
    check_eq("fetch_c3_m_req", {31'd0, m_req}, 32'd0);
    check_eq("fetch_c3_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);
    check_eq("fetch_c4_i_ack_n", {31'd0, i_ack_n}, 32'd1);

    // Reset in the middle of a fetch that memory never answers.
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'hD000_0040;
    repeat (2) @(negedge clk);
    check_eq("midrst_busy", {31'd0, m_req}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_m_req", {31'd0, m_req}, 32'd0);
    check_eq("midrst_i_ack_n", {31'd0, i_ack_n}, 32'd1);
    check_eq("midrst_state", {30'd0, dbg_state}, 32'd0);
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acks_seen = 0;
    mreq_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (!i_ack_n || !d_ack_n) acks_seen++;
      if (m_req) mreq_seen++;
    end
    check_eq("midrst_no_ack", acks_seen, 32'd0);
    check_eq("midrst_no_mreq", mreq_seen, 32'd0);

    // Scoreboard phase
    starve_m = 0;
    last_d_m = 32'd0;
    mon_en   = 1;

    // Simultaneous fetch and load: data first.
    i_items.push_back(mk_item(1'b0, 2'b00, 32'h0000_0200, 32'd0));
    d_items.push_back(mk_item(1'b0, 2'b00, 32'h0800_0004, 32'd0));
    run_round();

    // Byte store leaves d_rdata at the previous load value.
    d_items.push_back(mk_item(1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041));
    run_round();

    // Starvation: 4 data grants, then the fetch, then data resumes.
    i_items.push_back(mk_item(1'b0, 2'b00, 32'h0000_0300, 32'd0));
    for (int k = 0; k < 6; k++)
      d_items.push_back(mk_item(1'b0, 2'b00, 32'h0000_1000 + 32'(k * 16), 32'd0));
    run_round();

    // Timeout on a load, then acknowledge on the timeout edge, and one
    // cycle earlier.
    d_items.push_back(mk_item(1'b0, 2'b00, 32'hD000_0010, 32'd0));
    run_round();
    i_items.push_back(mk_item(1'b0, 2'b00, 32'hB000_0020, 32'd0));
    d_items.push_back(mk_item(1'b1, 2'b01, 32'hC000_0008, 32'hCAFE_F00D));
    run_round();

    // Random rounds
    for (int r = 0; r < 40; r++) begin
      int ni;
      int nd;
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 6);
      if (ni == 0 && nd == 0) nd = 1;
      for (int k = 0; k < ni; k++)
        i_items.push_back(mk_item(1'b0, 2'b00, rand_addr(), 32'd0));
      for (int k = 0; k < nd; k++)
        d_items.push_back(mk_item(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                                  rand_addr(), $urandom));
      run_round();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants taken while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 16: number of BUSY cycles without m_ack_n before a transaction is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have instruction-side ports: i_req in 1; i_addr in 32; i_rdata out 32; i_ack_n out 1 (active-low completion).
REQ-006 SHALL have data-side ports: d_req in 1; d_write in 1; d_size in 2 (00 word, 01 half, 10 byte); d_addr in 32; d_wdata in 32; d_rdata out 32; d_ack_n out 1.
REQ-007 SHALL have memory-side ports: m_req out 1; m_write out 1; m_size out 2; m_addr out 32; m_wdata out 32; m_rdata in 32; m_ack_n in 1 (active-low).
REQ-008 SHALL have port bus_err, output, 1 bit: one-cycle pulse on a timeout abort; and err_addr, output, 32 bits: address of the last aborted transaction.

Function
REQ-009 SHALL implement states IDLE, BUSY_I, BUSY_D and RESP.
REQ-010 In IDLE, SHALL grant d_req over i_req, except when the starvation count equals STARVE_LIMIT and both are high; i_req then wins.
REQ-011 On a grant in IDLE, SHALL register the request into m_* so that m_req=1 in the next cycle; state goes to BUSY_I or BUSY_D.
REQ-012 Instruction grants SHALL drive m_write=0, m_size=00, m_addr=i_addr and m_wdata=0.
REQ-013 Data grants SHALL drive d_write, d_size, d_addr and d_wdata onto m_*.
REQ-014 m_* SHALL remain stable for the whole BUSY state.
REQ-015 m_ack_n SHALL be ignored in IDLE and RESP.
REQ-016 When m_ack_n is sampled low in BUSY_x, SHALL move to RESP and drop m_req to 0 in RESP.
REQ-017 In RESP, the granted side's ack_n SHALL be 0 for exactly one cycle, then the FSM returns to IDLE.
REQ-018 For a read completing in RESP, the granted side's rdata SHALL equal the m_rdata captured at the acknowledging edge.
REQ-019 For a data write, d_rdata SHALL keep its previous value.
REQ-020 The ungranted side's ack_n SHALL stay 1 at all times.
REQ-021 Round trip SHALL be: req seen in IDLE at cycle 0; m_req at cycle 1; m_ack_n low at cycle k>=1; ack_n low at cycle k+1. Minimum is 3 cycles.
REQ-022 Requests arriving while not in IDLE SHALL wait.
REQ-023 Requesters hold req and their inputs until their ack_n pulses, and drop req the cycle after ack.
REQ-024 The starvation counter SHALL increment on a data grant while i_req=1.
REQ-025 The starvation counter SHALL clear on any instruction grant, or on a data grant while i_req=0.
REQ-026 The starvation counter SHALL saturate at STARVE_LIMIT.
REQ-027 A BUSY cycle counter SHALL clear on entry to BUSY. If it reaches TIMEOUT-1 with m_ack_n still high, SHALL go to RESP.
REQ-028 In a timeout RESP: ack_n pulses, rdata=0, bus_err=1 for that cycle, and err_addr is loaded with m_addr.
REQ-029 If m_ack_n arrives on the same edge as the timeout, SHALL treat the transaction as a normal completion with no bus_err.

Reset
REQ-030 While rst=0, SHALL force state IDLE, all counters 0, m_req=0, m_write=0, m_size=00, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, err_addr=0, i_ack_n=1, d_ack_n=1 and bus_err=0, immediately and regardless of clk.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack pulse.
REQ-032 The first grant after reset release SHALL occur at the earliest on the first rising edge with rst=1.

Verification
REQ-033 Instruction fetch: i_req, i_addr=0x100, memory acks in 1 cycle with 0x00000513 -> m_req=1 at cycle 1 with m_addr=0x100, m_size=00; i_ack_n=0 at cycle 3 with i_rdata=0x00000513.
REQ-034 Simultaneous requests: i_req and d_req (load 0x08000004) in the same cycle -> data granted first; instruction granted in the IDLE after the data RESP.
REQ-035 Starvation: STARVE_LIMIT=4, d_req continuously high and i_req high -> 4 data grants, then 1 instruction grant, then data resumes.
REQ-036 Byte store: d_write=1, d_size=10, d_addr=0xF0000000, d_wdata=0x41 -> m_write=1, m_size=10, m_wdata=0x41; d_ack_n pulses; d_rdata unchanged.
REQ-037 Timeout: TIMEOUT=16, m_ack_n held high -> RESP after 16 BUSY cycles with bus_err=1 for one cycle, err_addr=m_addr, d_rdata=0.
REQ-038 Reset mid-BUSY: rst=0 at cycle 2 of a fetch -> m_req=0 and i_ack_n=1 with no clock edge needed; no ack pulse follows after release.
